mem_access_controller: RTL
==========================

Name: mem_access_controller

Overview:
- Initiator-side controller for the ternary word memory. Sits between the CPU core (or program loader) and the memory array.
- Accepts single-word write requests and single- or multi-word (burst) read requests over a valid/ready handshake.
- Sequences the memory's read_enable, write_enable, address and data_in strobes, and returns read data and write acknowledgements on a valid/ready response channel.
- Trits are 2-bit coded: 00=0, 01=1, 10=2; 11 is illegal.

Parameters:
WORD_SIZE, 9, trits per data word (bus width 2*WORD_SIZE)
MEM_ADDR_SIZE, 3, trits per address (bus width 2*MEM_ADDR_SIZE)
LEN_W, 4, width of the burst-length field (max burst 2**LEN_W-1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  1=write single word, 0=read burst
req_addr  input  2*MEM_ADDR_SIZE  start address (trit-coded)
req_wdata  input  2*WORD_SIZE  write data
req_len  input  LEN_W  read burst length in words; 0 treated as 1; ignored on writes
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  2*WORD_SIZE  read data (all zero for write acks)
resp_last  output  1  final response of the request
resp_error  output  1  request rejected (optional feature only)
mem_read_enable  output  1  to memory read_enable
mem_write_enable  output  1  to memory write_enable
mem_address  output  2*MEM_ADDR_SIZE  to memory address
mem_data_in  output  2*WORD_SIZE  to memory data_in
mem_data_out  input  2*WORD_SIZE  from memory; registered, valid the cycle after a read strobe

Behaviour:
Reset
- While reset=0, all outputs are 0, the state is IDLE, and any pending burst is discarded immediately (asynchronous).
- Memory contents are untouched; the controller only drops its strobes.

FSM states: IDLE, RD_ISSUE, RD_DATA, RD_RESP, WR_ISSUE, WR_ACK, ERR_RESP.
- req_ready=1 only in IDLE. A request is accepted on an edge with req_valid&&req_ready. At acceptance, address, wdata and length are registered; a length of 0 is loaded as 1.
- Read acceptance -> RD_ISSUE. For exactly one cycle, mem_read_enable=1 and mem_address=current address.
- RD_ISSUE -> RD_DATA. In RD_DATA, mem_data_out is sampled into resp_rdata at the cycle end.
- RD_DATA -> RD_RESP, with resp_valid=1 and resp_last=(remaining==1).
- Latency: first resp_valid appears 3 cycles after the accepting edge.
- RD_RESP holds resp_valid and resp_rdata stable until resp_ready.
  - On handshake with remaining>1: address <= ternary increment (222->000 wraps silently), remaining decrements, -> RD_ISSUE.
  - On handshake otherwise -> IDLE.
- Write acceptance -> WR_ISSUE. For one cycle, mem_write_enable=1, mem_address=addr, mem_data_in=wdata.
- WR_ISSUE -> WR_ACK with resp_valid=1, resp_last=1, resp_rdata=0; hold until resp_ready, then -> IDLE.
- mem_read_enable and mem_write_enable are never high together and are decoded from the state register only. There is no combinational path from any input to any mem_* output.
- resp_ready high with resp_valid low is ignored. A request arriving while busy waits, since req_ready=0.
- Back-to-back: IDLE is re-entered for at least one cycle between requests.
- Reset asserted mid-burst: the response is abandoned; no further strobes are issued.

Optional Feature:
MEM_ACCESS_CONTROLLER_TRIT_CHECK_EN
- Defined: at acceptance, any 11 trit in req_addr, or in req_wdata for writes, routes to ERR_RESP. No memory strobe is issued. One response is returned with resp_error=1, resp_last=1, resp_rdata=0, held until resp_ready, then IDLE.
- Undefined: resp_error is tied to 0, codes pass through unchanged, and the incrementer treats 11 as 2.

Decomposition:
- Shared header parameters.vh holds:
  - WORD_SIZE and MEM_ADDR_SIZE defaults
  - trit code constants TRIT_ZERO, TRIT_ONE, TRIT_TWO, TRIT_ILLEGAL
  - FSM state encodings
- One sub-module, ternary_incrementer: combinational, N-trit parameter, adds 1 with per-trit carry, outputs sum and carry_out. It is reused by the program counter later.

Test Plan:
- Write 000000000000000110 at address 000110 (trits 0,1,2), then read len=1 at the same address -> one mem_write_enable pulse; write ack with rdata=0 and last=1; read resp_rdata equals the written word 3 cycles after acceptance, last=1.
- Preload addr 00,01,02 (trits) = A,B,C, then read len=3 from address 000000 with resp_ready=1 -> rdata A,B,C on successive responses with mem_address 000000, 000001, 000010; last=1 only on C.
- Burst len=2 from address 101010 (222) -> second read strobe at 000000 (wrap); 2 responses.
- Hold resp_ready=0 for 5 cycles during a read -> resp_valid and resp_rdata stable, no further mem strobes, req_ready=0; completes after resp_ready=1.
- Drop reset to 0 mid-burst (in RD_RESP) -> all outputs 0 asynchronously; after release, req_ready=1 and no stray strobes.
- With TRIT_CHECK_EN, request addr 110000 -> no mem strobe; resp_error=1, last=1, rdata=0. Without the macro, the same request issues a read at 110000.

Source files
------------

// File: rtl/mem_access_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_controller_pkg
//  Description : Shared defaults, trit codes and FSM encodings for the
//                ternary memory access controller and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_controller_pkg;

  // Default geometry of the ternary word memory.
  localparam int DEF_WORD_SIZE     = 9;  // trits per data word
  localparam int DEF_MEM_ADDR_SIZE = 3;  // trits per address
  localparam int DEF_LEN_W         = 4;  // burst-length field width

  // Two-bit trit codes.
  localparam logic [1:0] TRIT_ZERO    = 2'b00;
  localparam logic [1:0] TRIT_ONE     = 2'b01;
  localparam logic [1:0] TRIT_TWO     = 2'b10;
  localparam logic [1:0] TRIT_ILLEGAL = 2'b11;

  // Controller FSM states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DATA  = 3'd2,
    RD_RESP  = 3'd3,
    WR_ISSUE = 3'd4,
    WR_ACK   = 3'd5,
    ERR_RESP = 3'd6
  } state_e;

  // True when any of the low n_trits trits of code carries the illegal 11 code.
  function automatic logic has_illegal_trit(input logic [63:0] code, input int n_trits);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n_trits && code[2*i +: 2] == TRIT_ILLEGAL) found = 1'b1;
    end
    return found;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ternary_incrementer.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_incrementer
//  Description : Combinational N-trit +1 with ripple carry. A trit coded 11
//                is treated as 2 when it receives a carry; trits without an
//                incoming carry pass through unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module ternary_incrementer
  import mem_access_controller_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N-1:0] value,
  output logic [2*N-1:0] sum,
  output logic           carry_out
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_trit
    logic [1:0] trit;
    logic       saturated;
    assign trit      = value[2*gi +: 2];
    assign saturated = (trit >= TRIT_TWO);
    assign sum[2*gi +: 2] = !carry[gi] ? trit :
                            saturated  ? TRIT_ZERO : (trit + 2'd1);
    assign carry[gi+1]    = carry[gi] & saturated;
  end

  assign carry_out = carry[N];

endmodule
`default_nettype wire

// File: rtl/mem_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_controller
//  Description : Initiator-side controller for the ternary word memory.
//                Single-word writes and burst reads over valid/ready, with
//                fully registered memory strobes and response outputs.
//                Optional macro MEM_ACCESS_CONTROLLER_TRIT_CHECK_EN rejects
//                requests carrying an illegal 11 trit with resp_error.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int LEN_W         = DEF_LEN_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [2*MEM_ADDR_SIZE-1:0] req_addr,
  input  logic [2*WORD_SIZE-1:0]     req_wdata,
  input  logic [LEN_W-1:0]           req_len,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [2*WORD_SIZE-1:0]     resp_rdata,
  output logic                       resp_last,
  output logic                       resp_error,
  output logic                       mem_read_enable,
  output logic                       mem_write_enable,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_address,
  output logic [2*WORD_SIZE-1:0]     mem_data_in,
  input  logic [2*WORD_SIZE-1:0]     mem_data_out
);

  localparam int AW = 2*MEM_ADDR_SIZE;
  localparam int DW = 2*WORD_SIZE;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_last_q, resp_last_d;
  logic            mem_read_enable_q, mem_read_enable_d;
  logic            mem_write_enable_q, mem_write_enable_d;
  logic [AW-1:0]   mem_address_q, mem_address_d;
  logic [DW-1:0]   mem_data_in_q, mem_data_in_d;

  logic [AW-1:0]   addr_inc;
  logic            addr_wrap_unused;
  logic            accept;
  logic            bad_req;

  // Next burst address; wrap from 222 to 000 is silent.
  ternary_incrementer #(
    .N (MEM_ADDR_SIZE)
  ) u_addr_inc (
    .value     (addr_q),
    .sum       (addr_inc),
    .carry_out (addr_wrap_unused)
  );

  assign accept = req_valid && req_ready_q;

`ifdef MEM_ACCESS_CONTROLLER_TRIT_CHECK_EN
  assign bad_req = has_illegal_trit(64'(req_addr), MEM_ADDR_SIZE) ||
                   (req_write && has_illegal_trit(64'(req_wdata), WORD_SIZE));
`else
  assign bad_req = 1'b0;
`endif

  // Next-state and next-output computation; outputs follow the next state so
  // every external output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = req_addr;
          remaining_d = (req_len == '0) ? LEN_W'(1) : req_len;
          if (bad_req) begin
            state_d = ERR_RESP;
            rdata_d = '0;
          end else if (req_write) begin
            state_d = WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA: begin
        rdata_d = mem_data_out;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        if (resp_ready) begin
          if (remaining_q > LEN_W'(1)) begin
            addr_d      = addr_inc;
            remaining_d = remaining_q - LEN_W'(1);
            state_d     = RD_ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WR_ISSUE: begin
        rdata_d = '0;
        state_d = WR_ACK;
      end
      WR_ACK, ERR_RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d        = (state_d == IDLE);
    mem_read_enable_d  = (state_d == RD_ISSUE);
    mem_write_enable_d = (state_d == WR_ISSUE);
    mem_address_d      = (state_d == RD_ISSUE || state_d == WR_ISSUE) ? addr_d : '0;
    // WR_ISSUE is only ever entered from an accepting IDLE cycle.
    mem_data_in_d      = (state_d == WR_ISSUE) ? req_wdata : '0;
    resp_valid_d       = (state_d == RD_RESP) || (state_d == WR_ACK) || (state_d == ERR_RESP);
    resp_last_d        = (state_d == RD_RESP) ? (remaining_d == LEN_W'(1)) :
                         ((state_d == WR_ACK) || (state_d == ERR_RESP));
  end

  // State and registered outputs; reset drops everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      remaining_q        <= '0;
      rdata_q            <= '0;
      req_ready_q        <= 1'b0;
      resp_valid_q       <= 1'b0;
      resp_last_q        <= 1'b0;
      mem_read_enable_q  <= 1'b0;
      mem_write_enable_q <= 1'b0;
      mem_address_q      <= '0;
      mem_data_in_q      <= '0;
    end else begin
      state_q            <= state_d;
      addr_q             <= addr_d;
      remaining_q        <= remaining_d;
      rdata_q            <= rdata_d;
      req_ready_q        <= req_ready_d;
      resp_valid_q       <= resp_valid_d;
      resp_last_q        <= resp_last_d;
      mem_read_enable_q  <= mem_read_enable_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_address_q      <= mem_address_d;
      mem_data_in_q      <= mem_data_in_d;
    end
  end

`ifdef MEM_ACCESS_CONTROLLER_TRIT_CHECK_EN
  logic resp_error_q, resp_error_d;

  assign resp_error_d = (state_d == ERR_RESP);

  // Error flag accompanies the single rejection response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) resp_error_q <= 1'b0;
    else        resp_error_q <= resp_error_d;
  end

  assign resp_error = resp_error_q;
`else
  assign resp_error = 1'b0;
`endif

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_last        = resp_last_q;
  assign mem_read_enable  = mem_read_enable_q;
  assign mem_write_enable = mem_write_enable_q;
  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;

endmodule
`default_nettype wire
